rij_trace_buf: RTL and testbench
================================

RIJ_TRACE_BUF -- requirements
Module: rij_trace_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries; must be a power of 2, at least 2.
REQ-002 The block SHALL have port clk_low, input, 1 bit: the CPU instruction clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 The block SHALL have ports PC, Inst_code and F, inputs, 32 bits each: the CPU's current program counter, instruction and ALU result.
REQ-005 The block SHALL have ports FR_ZF and FR_OF, inputs, 1 bit each: the CPU's zero and overflow flags.
REQ-006 The block SHALL have ports arm, disarm and clear, inputs, 1 bit each: single-cycle control pulses.
REQ-007 The block SHALL have port trig_pc, input, 32 bits: the trigger PC value.
REQ-008 The block SHALL have output rd_valid and input rd_ready, 1 bit each: the readout handshake.
REQ-009 The block SHALL have outputs rd_pc, rd_inst and rd_f (32 bits each) and rd_zf, rd_of (1 bit each): the head record.
REQ-010 The block SHALL have outputs count ($clog2(DEPTH)+1 bits, current fill level) and state (2 bits).

Function
REQ-011 The state encoding SHALL be IDLE=0, ARMED=1, CAPT=2, DONE=3.
REQ-012 IDLE SHALL go to ARMED on arm; ARMED SHALL go to CAPT in the cycle where PC==trig_pc; CAPT SHALL go to DONE on overflow (REQ-016); DONE SHALL go to ARMED on arm.
REQ-013 disarm SHALL force IDLE from any state and retain FIFO contents; disarm SHALL take priority over arm.
REQ-014 A capture condition SHALL exist in the ARMED cycle where PC==trig_pc (that cycle's record is the first written), and in every CAPT cycle.
REQ-015 On a capture, the record {PC, Inst_code, F, FR_ZF, FR_OF} SHALL be written at that rising edge; count and rd_valid SHALL reflect it the next cycle.
REQ-016 When count==DEPTH, a capture SHALL be accepted only if a pop occurs the same cycle; otherwise the sample SHALL be dropped and the state SHALL go to DONE.
REQ-017 rd_valid SHALL equal (count!=0); rd_* SHALL show the oldest entry (first-word fall-through), and SHALL be 0 when empty.
REQ-018 A pop SHALL occur when rd_valid && rd_ready, in any state; readout SHALL be independent of the FSM.
REQ-019 Simultaneous push and pop SHALL leave count unchanged.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 clear SHALL empty the FIFO (count=0, pointers=0) and suppress any push or pop in that cycle without changing state; clear together with arm SHALL flush and then enter ARMED.

Reset
REQ-022 While rst=0, the block SHALL hold state=IDLE, count=0, pointers=0, rd_valid=0 and all rd_* at 0, asynchronously.
REQ-023 Reset asserted mid-capture SHALL discard all stored records.
REQ-024 Storage array contents MAY be left unreset.

Configuration
REQ-025 When macro RIJ_TRACE_DEDUP_EN is defined, a CAPT-state capture SHALL be suppressed if PC equals the PC of the last written record, so that stalled or repeated-PC cycles are not recorded.
REQ-026 When RIJ_TRACE_DEDUP_EN is undefined, every CAPT cycle SHALL capture.
REQ-027 The last-PC register (with RIJ_TRACE_DEDUP_EN) SHALL reset to 0, and the trigger-cycle capture SHALL never be suppressed.

Structure
REQ-028 Package rij_trace_pkg SHALL hold the state encoding constants and the record width (98) with its field offsets.
REQ-029 Sub-module rij_trace_fifo (parameter DEPTH; push, pop, clear, din, dout, count) SHALL hold the storage and pointers.
REQ-030 rij_trace_buf SHALL contain the FSM, trigger compare, dedup logic and the record pack/unpack.

Verification
REQ-031 Reset mid-capture: capture 5 records, then rst=0 for one cycle -> state=0, count=0, rd_valid=0 immediately, without waiting for a clock edge.
REQ-032 Trigger: arm, trig_pc=0x0000_0010, PC steps 0x0,0x4,...; with DEPTH=16 and rd_ready=0 -> first record rd_pc=0x10, state=2; 16 records 0x10..0x4C stored; sample 0x50 dropped; state=3; count=16.
REQ-033 Wrap with streaming: rd_ready=1 held high during CAPT for 40 cycles -> count stays at 1, state remains 2, and rd_pc increments by 4 each cycle, in order, across pointer wrap.
REQ-034 Dedup, macro defined: in CAPT, PC held at 0x20 for 3 cycles then 0x24 -> records 0x20 and 0x24 only. Macro undefined -> 4 records.
REQ-035 Control priority: arm and disarm in the same cycle -> state=0; clear and arm in DONE with count=16 -> count=0, state=1.
REQ-036 Flags: a captured cycle with FR_ZF=1, FR_OF=0, F=0 -> that record reads rd_zf=1, rd_of=0, rd_f=0.

Source files
------------

// File: rtl/rij_trace_pkg.sv
// rij_trace_pkg: shared state encoding and trace record layout
// for the rij_trace_buf instruction trace buffer.
package rij_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } trace_st_e;

  localparam int REC_W    = 98;
  localparam int PC_LSB   = 66;
  localparam int INST_LSB = 34;
  localparam int F_LSB    = 2;
  localparam int ZF_BIT   = 1;
  localparam int OF_BIT   = 0;

  function automatic logic [REC_W-1:0] rec_pack(
    input logic [31:0] pc,
    input logic [31:0] inst,
    input logic [31:0] f,
    input logic        zf,
    input logic        of
  );
    return {pc, inst, f, zf, of};
  endfunction

endpackage

// File: rtl/rij_trace_fifo.sv
// rij_trace_fifo: first-word fall-through record storage;
// dout reads zero while empty.
import rij_trace_pkg::*;

module rij_trace_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [REC_W-1:0]         din,
  output logic [REC_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = (count != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/rij_trace_buf.sv
// rij_trace_buf: triggered CPU trace capture into a FIFO.
// Define RIJ_TRACE_DEDUP_EN to skip repeated-PC captures.
import rij_trace_pkg::*;

module rij_trace_buf #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_low,
  input  logic                   rst,
  input  logic [31:0]            PC,
  input  logic [31:0]            Inst_code,
  input  logic [31:0]            F,
  input  logic                   FR_ZF,
  input  logic                   FR_OF,
  input  logic                   arm,
  input  logic                   disarm,
  input  logic                   clear,
  input  logic [31:0]            trig_pc,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [31:0]            rd_pc,
  output logic [31:0]            rd_inst,
  output logic [31:0]            rd_f,
  output logic                   rd_zf,
  output logic                   rd_of,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  trace_st_e        st;
  logic             hit;
  logic             dup;
  logic             cap;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [REC_W-1:0] din;
  logic [REC_W-1:0] dout;

  assign hit  = (st == ARMED) && (PC == trig_pc);
  assign cap  = hit || ((st == CAPT) && !dup);
  assign full = (count == FULL);
  assign pop  = rd_valid && rd_ready && !clear;
  assign push = cap && !clear && (!full || pop);
  assign drop = cap && !clear && full && !pop;
  assign din  = rec_pack(PC, Inst_code, F, FR_ZF, FR_OF);

`ifdef RIJ_TRACE_DEDUP_EN
  logic [31:0] last_pc;

  always_ff @(posedge clk_low or negedge rst) begin
    if (!rst)      last_pc <= '0;
    else if (push) last_pc <= PC;
  end

  // trigger cycle is ARMED, so it is never deduplicated
  assign dup = (st == CAPT) && (PC == last_pc);
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk_low or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
    end else if (disarm) begin
      st <= IDLE;
    end else if (arm && ((st == IDLE) || (st == DONE))) begin
      st <= ARMED;
    end else if (drop) begin
      st <= DONE;
    end else if (hit) begin
      st <= CAPT;
    end
  end

  rij_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_low),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (din),
    .dout  (dout),
    .count (count)
  );

  assign state    = st;
  assign rd_valid = (count != '0);
  assign rd_pc    = dout[PC_LSB +: 32];
  assign rd_inst  = dout[INST_LSB +: 32];
  assign rd_f     = dout[F_LSB +: 32];
  assign rd_zf    = dout[ZF_BIT];
  assign rd_of    = dout[OF_BIT];

endmodule

// File: tb/tb_rij_trace_buf.sv
// tb_rij_trace_buf: directed scenarios plus random control traffic,
// checked against a queue-based trace model.
module tb_rij_trace_buf;

  localparam int DEPTH = 16;
`ifdef RIJ_TRACE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic        clk_low = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] Inst_code = '0;
  logic [31:0] F = '0;
  logic        FR_ZF = 1'b0;
  logic        FR_OF = 1'b0;
  logic        arm = 1'b0;
  logic        disarm = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_inst;
  logic [31:0] rd_f;
  logic        rd_zf;
  logic        rd_of;
  logic [4:0]  count;
  logic [1:0]  state;

  rij_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk_low   (clk_low),
    .rst       (rst),
    .PC        (PC),
    .Inst_code (Inst_code),
    .F         (F),
    .FR_ZF     (FR_ZF),
    .FR_OF     (FR_OF),
    .arm       (arm),
    .disarm    (disarm),
    .clear     (clear),
    .trig_pc   (trig_pc),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_pc     (rd_pc),
    .rd_inst   (rd_inst),
    .rd_f      (rd_f),
    .rd_zf     (rd_zf),
    .rd_of     (rd_of),
    .count     (count),
    .state     (state)
  );

  always #5 clk_low = ~clk_low;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] f;
    logic        zf;
    logic        of;
  } rec_t;

  rec_t        q[$];
  int          m_st;
  logic [31:0] m_last;

  wire [105:0] dut_vec = {state, count, rd_valid, rd_pc,
                          rd_inst, rd_f, rd_zf, rd_of};

  function automatic void m_reset();
    q.delete();
    m_st = 0;
    m_last = '0;
  endfunction

  // One clock of trace behaviour, from the current input values.
  function automatic void m_step();
    bit   hit;
    bit   cap;
    bit   pop;
    bit   drop;
    rec_t r;
    hit  = (m_st == 1) && (PC == trig_pc);
    cap  = hit || ((m_st == 2) && !(DEDUP && PC == m_last));
    pop  = (q.size() > 0) && rd_ready && !clear;
    drop = 1'b0;
    if (clear) begin
      q.delete();
    end else begin
      if (cap && q.size() == DEPTH && !pop) drop = 1'b1;
      if (pop) void'(q.pop_front());
      if (cap && !drop) begin
        r = '{PC, Inst_code, F, FR_ZF, FR_OF};
        q.push_back(r);
        m_last = PC;
      end
    end
    if (disarm) m_st = 0;
    else if (arm && (m_st == 0 || m_st == 3)) m_st = 1;
    else if (drop) m_st = 3;
    else if (hit) m_st = 2;
  endfunction

  function automatic logic [105:0] exp_vec();
    rec_t h;
    h = '{default: 0};
    if (q.size() > 0) h = q[0];
    return {2'(m_st), 5'(q.size()), logic'(q.size() > 0),
            h.pc, h.inst, h.f, h.zf, h.of};
  endfunction

  task automatic cyc();
    @(posedge clk_low);
    m_step();
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    #2;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_vec: got %h want %h", dut_vec, exp_vec());
    end
    n_cmp++;
    if (state !== 2'd0 || count !== 5'd0 || rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: got st=%0d cnt=%0d v=%0d want 0 0 0",
               state, count, rd_valid);
    end
    @(negedge clk_low);
    rst = 1'b1;
  endtask

  task automatic test_trigger();
    trig_pc = 32'h10;
    rd_ready = 1'b0;
    PC = 32'hFFFF_0000;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    for (int i = 0; i < 23; i++) begin
      PC = 32'(4 * i);
      Inst_code = $urandom;
      F = $urandom;
      FR_ZF = 1'($urandom);
      FR_OF = 1'($urandom);
      cyc();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL trig_vec[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
      if (i == 4) begin
        n_cmp++;
        if (rd_pc !== 32'h10 || state !== 2'd2) begin
          n_bad++;
          $display("FAIL trig_first: got pc=%h st=%0d want 10 2", rd_pc, state);
        end
      end
    end
    n_cmp++;
    if (state !== 2'd3 || count !== 5'd16 || rd_pc !== 32'h10) begin
      n_bad++;
      $display("FAIL trig_done: got st=%0d cnt=%0d pc=%h want 3 16 10",
               state, count, rd_pc);
    end
  endtask

  task automatic test_control();
    clear = 1'b1;
    arm = 1'b1;
    cyc();
    clear = 1'b0;
    arm = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || state !== 2'd1) begin
      n_bad++;
      $display("FAIL clear_arm: got cnt=%0d st=%0d want 0 1", count, state);
    end
    PC = 32'hAAAA_0000;
    arm = 1'b1;
    disarm = 1'b1;
    cyc();
    cyc();
    arm = 1'b0;
    disarm = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL arm_disarm: got st=%0d want 0", state);
    end
  endtask

  task automatic test_reset_mid();
    trig_pc = 32'h100;
    PC = 32'h0;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      PC = 32'h100 + 32'(4 * i);
      cyc();
    end
    n_cmp++;
    if (count !== 5'd5 || state !== 2'd2) begin
      n_bad++;
      $display("FAIL mid_fill: got cnt=%0d st=%0d want 5 2", count, state);
    end
    rst = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if (state !== 2'd0 || count !== 5'd0 || rd_valid !== 1'b0 ||
        rd_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got st=%0d cnt=%0d v=%0d pc=%h want 0 0 0 0",
               state, count, rd_valid, rd_pc);
    end
    #1;
    rst = 1'b1;
  endtask

  task automatic test_wrap_stream();
    logic [31:0] prev;
    trig_pc = 32'h200;
    PC = 32'h0;
    rd_ready = 1'b1;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    PC = 32'h200;
    cyc();
    prev = rd_pc;
    for (int i = 1; i <= 40; i++) begin
      PC = 32'h200 + 32'(4 * i);
      cyc();
      n_cmp++;
      if (count !== 5'd1 || state !== 2'd2 || rd_pc !== prev + 32'd4 ||
          dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got cnt=%0d st=%0d pc=%h want 1 2 %h",
                 i, count, state, rd_pc, prev + 32'd4);
      end
      prev = prev + 32'd4;
    end
    disarm = 1'b1;
    clear = 1'b1;
    cyc();
    disarm = 1'b0;
    clear = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic test_dedup();
    logic [31:0] pcs [4];
    pcs[0] = 32'h20;
    pcs[1] = 32'h20;
    pcs[2] = 32'h20;
    pcs[3] = 32'h24;
    trig_pc = 32'h20;
    PC = 32'h0;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      PC = pcs[i];
      cyc();
    end
    n_cmp++;
    if (count !== (DEDUP ? 5'd2 : 5'd4) || rd_pc !== 32'h20) begin
      n_bad++;
      $display("FAIL dedup_cnt: got cnt=%0d pc=%h want %0d 20",
               count, rd_pc, DEDUP ? 2 : 4);
    end
    disarm = 1'b1;
    rd_ready = 1'b1;
    PC = 32'h500;
    cyc();
    disarm = 1'b0;
    n_cmp++;
    if (rd_pc !== (DEDUP ? 32'h24 : 32'h20) || dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL dedup_second: got pc=%h want %h",
               rd_pc, DEDUP ? 32'h24 : 32'h20);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL dedup_drain[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_flags();
    trig_pc = 32'h300;
    PC = 32'h0;
    clear = 1'b1;
    arm = 1'b1;
    cyc();
    clear = 1'b0;
    arm = 1'b0;
    PC = 32'h300;
    Inst_code = 32'hDEAD_BEEF;
    F = 32'h0;
    FR_ZF = 1'b1;
    FR_OF = 1'b0;
    cyc();
    n_cmp++;
    if (rd_zf !== 1'b1 || rd_of !== 1'b0 || rd_f !== 32'h0 ||
        rd_pc !== 32'h300 || rd_inst !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL flags: got zf=%0d of=%0d f=%h pc=%h want 1 0 0 300",
               rd_zf, rd_of, rd_f, rd_pc);
    end
    disarm = 1'b1;
    clear = 1'b1;
    cyc();
    disarm = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_random();
    trig_pc = 32'h8;
    for (int i = 0; i < 1500; i++) begin
      arm = ($urandom_range(0, 15) == 0);
      disarm = ($urandom_range(0, 39) == 0);
      clear = ($urandom_range(0, 49) == 0);
      rd_ready = ($urandom_range(0, 3) == 0);
      PC = 32'(4 * $urandom_range(0, 7));
      Inst_code = $urandom;
      F = $urandom;
      FR_ZF = 1'($urandom);
      FR_OF = 1'($urandom);
      if (i % 300 == 299) trig_pc = 32'(4 * $urandom_range(0, 7));
      cyc();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL rand[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    arm = 1'b0;
    disarm = 1'b0;
    clear = 1'b0;
    rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_control();
    test_reset_mid();
    test_wrap_stream();
    test_dedup();
    test_flags();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
